// File: rtl/move_step_scheduler.sv
// move_step_scheduler: periodic move tick, per-player direction latch and
// two-player step sequencing with collision-based round outcome.
module move_step_scheduler #(
    parameter int TICK_DIV    = 4000000,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [2:0]  dir1_in,
    input  logic [2:0]  dir2_in,
    output logic        step_req1,
    output logic [2:0]  step_dir1,
    input  logic        step_ack1,
    input  logic        collision1,
    output logic        step_req2,
    output logic [2:0]  step_dir2,
    input  logic        step_ack2,
    input  logic        collision2,
    output logic        game_over,
    output logic [1:0]  winner,
    output logic        fault,
    output logic [15:0] step_count
);

    localparam logic [2:0] WAIT  = 3'd0;
    localparam logic [2:0] RIGHT = 3'd1;
    localparam logic [2:0] LEFT  = 3'd2;
    localparam logic [2:0] DOWN  = 3'd3;
    localparam logic [2:0] UP    = 3'd4;

    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int AW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ACK_LAST  = AW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        MOVE1,
        MOVE2,
        EVAL,
        OVER
    } state_t;

    state_t        state;
    logic [TW-1:0] tick_cnt;
    logic [AW-1:0] ack_cnt;
    logic          col1;
    logic          col2;
    logic [2:0]    nxt1;
    logic [2:0]    nxt2;
    logic          tmo_hit;

    function automatic logic [2:0] opposite(input logic [2:0] d);
        logic [2:0] o;
        case (d)
            RIGHT:   o = LEFT;
            LEFT:    o = RIGHT;
            DOWN:    o = UP;
            UP:      o = DOWN;
            default: o = WAIT;
        endcase
        return o;
    endfunction

    // WAIT and immediate reversals keep the current heading
    function automatic logic [2:0] next_dir(input logic [2:0] cur,
                                            input logic [2:0] req);
        logic [2:0] n;
        n = (req > UP) ? WAIT : req;
        if (n == WAIT || (cur != WAIT && n == opposite(cur)))
            return cur;
        return n;
    endfunction

    assign nxt1    = next_dir(step_dir1, dir1_in);
    assign nxt2    = next_dir(step_dir2, dir2_in);
    assign tmo_hit = (ack_cnt == ACK_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            ack_cnt    <= '0;
            col1       <= 1'b0;
            col2       <= 1'b0;
            step_req1  <= 1'b0;
            step_req2  <= 1'b0;
            step_dir1  <= WAIT;
            step_dir2  <= WAIT;
            game_over  <= 1'b0;
            winner     <= 2'b00;
            fault      <= 1'b0;
            step_count <= '0;
        end else if (state == IDLE || !run) begin
            // idle, or abort from any active state; fault is sticky
            state      <= (state == IDLE && run) ? WAIT_TICK : IDLE;
            tick_cnt   <= '0;
            ack_cnt    <= '0;
            col1       <= 1'b0;
            col2       <= 1'b0;
            step_req1  <= 1'b0;
            step_req2  <= 1'b0;
            step_dir1  <= WAIT;
            step_dir2  <= WAIT;
            game_over  <= 1'b0;
            winner     <= 2'b00;
            step_count <= '0;
        end else begin
            unique case (state)
                WAIT_TICK: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt  <= '0;
                        step_dir1 <= nxt1;
                        step_dir2 <= nxt2;
                        step_req1 <= (nxt1 != WAIT);
                        ack_cnt   <= '0;
                        state     <= MOVE1;
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                MOVE1: begin
                    if (!step_req1 || step_ack1 || tmo_hit) begin
                        col1      <= step_req1 && step_ack1 && collision1;
                        fault     <= fault | (step_req1 && !step_ack1);
                        step_req1 <= 1'b0;
                        step_req2 <= (step_dir2 != WAIT);
                        ack_cnt   <= '0;
                        state     <= MOVE2;
                    end else begin
                        ack_cnt <= ack_cnt + AW'(1);
                    end
                end
                MOVE2: begin
                    if (!step_req2 || step_ack2 || tmo_hit) begin
                        col2      <= step_req2 && step_ack2 && collision2;
                        fault     <= fault | (step_req2 && !step_ack2);
                        step_req2 <= 1'b0;
                        ack_cnt   <= '0;
                        state     <= EVAL;
                    end else begin
                        ack_cnt <= ack_cnt + AW'(1);
                    end
                end
                EVAL: begin
                    // a crashing player loses: winner bit is the other player
                    winner <= {col1, col2};
                    col1   <= 1'b0;
                    col2   <= 1'b0;
                    if (col1 || col2) begin
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else begin
                        if (step_count != 16'hFFFF)
                            step_count <= step_count + 16'd1;
                        tick_cnt <= '0;
                        state    <= WAIT_TICK;
                    end
                end
                OVER: begin
                    state <= OVER;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
